// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier operand front end.
package booth_pkg;

   typedef enum logic [1:0] {IDLE, CHECK_ON, PRESSED, CHECK_OFF} db_state_t;

   localparam int unsigned SYNC_DEFAULT = 2;

endpackage

// File: rtl/antirrebote.sv
// Start-button synchroniser plus counter-based debounce FSM.
// Emits a registered one-cycle pulse on each accepted press.
module antirrebote
   import booth_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic CLK100MHZ,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(DEBOUNCE_CYCLES);
   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntWidth-1:0]    cnt_q, cnt_d;
   db_state_t              state_q, state_d;
   logic                   pulse_q, pulse_d;
   logic                   pb_sync;

   assign pb_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pb_sync) begin
               state_d = CHECK_ON;
               cnt_d   = CntOne;
            end
         end
         CHECK_ON: begin
            if (!pb_sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = PRESSED;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else if (cnt_q < CntMax) begin
               cnt_d = cnt_q + CntOne;
            end
         end
         PRESSED: begin
            if (!pb_sync) begin
               state_d = CHECK_OFF;
               cnt_d   = CntOne;
            end
         end
         CHECK_OFF: begin
            if (pb_sync) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q < CntMax) begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         state_q <= IDLE;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         pulse_q <= pulse_d;
      end
   end

   // Debounced level only changes once a check state has been confirmed.
   assign level = (state_q == PRESSED) || (state_q == CHECK_OFF);
   assign pulse = pulse_q;

endmodule

// File: rtl/captura_operandos.sv
// Operand capture front end: synchronises switches, debounces start, latches
// operands on each press and offers them to the multiplier via valid/ready.
module captura_operandos
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned SYNC_STAGES     = SYNC_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic               CLK100MHZ,
   input  logic               reset,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic               pb_entrada,
   input  logic               ready,
   output logic [WIDTH-1:0]   multiplicando,
   output logic [WIDTH-1:0]   multiplicador,
   output logic               valid,
   output logic               pb_salida,
   output logic               overrun,
   output logic [2*WIDTH-1:0] LED,
   output logic               LED_reset,
   output logic               LED_pb
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] a_sync_q, a_sync_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] b_sync_q, b_sync_d;
   logic [WIDTH-1:0]                  a_sync, b_sync;
   logic [WIDTH-1:0]                  mc_q, mc_d, mr_q, mr_d;
   logic                              valid_q, valid_d;
   logic                              overrun_q, overrun_d;
   logic                              press;

   antirrebote #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_antirrebote (
      .CLK100MHZ(CLK100MHZ),
      .reset    (reset),
      .raw      (pb_entrada),
      .level    (LED_pb),
      .pulse    (press)
   );

   always_comb begin
      a_sync_d    = a_sync_q;
      b_sync_d    = b_sync_q;
      a_sync_d[0] = A;
      b_sync_d[0] = B;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         a_sync_d[i] = a_sync_q[i-1];
         b_sync_d[i] = b_sync_q[i-1];
      end
   end

   assign a_sync = a_sync_q[SYNC_STAGES-1];
   assign b_sync = b_sync_q[SYNC_STAGES-1];

   // A press is accepted only if the slot is empty or draining this cycle.
   always_comb begin
      mc_d      = mc_q;
      mr_d      = mr_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (press) begin
         if (!valid_q || ready) begin
            mc_d    = a_sync;
            mr_d    = b_sync;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         a_sync_q  <= '0;
         b_sync_q  <= '0;
         mc_q      <= '0;
         mr_q      <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         a_sync_q  <= a_sync_d;
         b_sync_q  <= b_sync_d;
         mc_q      <= mc_d;
         mr_q      <= mr_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign multiplicando = mc_q;
   assign multiplicador = mr_q;
   assign valid         = valid_q;
   assign overrun       = overrun_q;
   assign pb_salida     = press;
   assign LED           = {a_sync, b_sync};
   assign LED_reset     = reset;

endmodule

// File: tb/tb_captura_operandos.sv
// Directed bench for captura_operandos: 8-bit and 16-bit builds, debounce of 4.
module tb_captura_operandos;

   logic        clk;
   logic        reset;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic        pb, ready;

   logic [7:0]  mc8, mr8;
   logic        valid8, pbs8, ovr8, ledr8, ledpb8;
   logic [15:0] led8;
   logic [15:0] mc16, mr16;
   logic        valid16, pbs16, ovr16, ledr16, ledpb16;
   logic [31:0] led16;

   int n_vec = 0;
   int n_err = 0;

   captura_operandos #(
      .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
   ) dut8 (
      .CLK100MHZ(clk), .reset(reset), .A(a8), .B(b8), .pb_entrada(pb), .ready(ready),
      .multiplicando(mc8), .multiplicador(mr8), .valid(valid8), .pb_salida(pbs8),
      .overrun(ovr8), .LED(led8), .LED_reset(ledr8), .LED_pb(ledpb8)
   );

   captura_operandos #(
      .WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
   ) dut16 (
      .CLK100MHZ(clk), .reset(reset), .A(a16), .B(b16), .pb_entrada(pb), .ready(ready),
      .multiplicando(mc16), .multiplicador(mr16), .valid(valid16), .pb_salida(pbs16),
      .overrun(ovr16), .LED(led16), .LED_reset(ledr16), .LED_pb(ledpb16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       rdy;
      logic [7:0] mc;
      logic [7:0] mr;
      logic       v;
      logic       ov;
   } press_vec_t;

   press_vec_t tbl [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_pulse(output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (pbs8) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int n, output int cnt, output int first);
      cnt   = 0;
      first = -1;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (pbs8) begin
            if (cnt == 0) first = i;
            cnt++;
         end
      end
   endtask

   initial begin
      int lat, cnt, first;

      tbl[0] = '{a: 8'h33, b: 8'h44, rdy: 1'b0, mc: 8'h33, mr: 8'h44, v: 1'b1, ov: 1'b0};
      tbl[1] = '{a: 8'h22, b: 8'h11, rdy: 1'b0, mc: 8'h33, mr: 8'h44, v: 1'b1, ov: 1'b1};
      tbl[2] = '{a: 8'h55, b: 8'h66, rdy: 1'b1, mc: 8'h55, mr: 8'h66, v: 1'b1, ov: 1'b1};
      tbl[3] = '{a: 8'h80, b: 8'h7F, rdy: 1'b1, mc: 8'h80, mr: 8'h7F, v: 1'b1, ov: 1'b1};

      reset = 1'b0;
      pb    = 1'b0;
      ready = 1'b0;
      a8    = 8'h5A;
      b8    = 8'hA5;
      a16   = 16'h8000;
      b16   = 16'h7FFF;
      #1 reset = 1'b1;
      repeat (3) tick();

      check("rst_mc", {24'h0, mc8}, 32'h0);
      check("rst_mr", {24'h0, mr8}, 32'h0);
      check("rst_valid", {31'h0, valid8}, 32'h0);
      check("rst_pulse", {31'h0, pbs8}, 32'h0);
      check("rst_overrun", {31'h0, ovr8}, 32'h0);
      check("rst_led_pb", {31'h0, ledpb8}, 32'h0);
      check("rst_led", {16'h0, led8}, 32'h0);
      check("rst_led_reset", {31'h0, ledr8}, 32'h1);

      reset = 1'b0;
      tick();
      tick();
      check("led_after_sync", {16'h0, led8}, 32'h5AA5);
      check("led_reset_low", {31'h0, ledr8}, 32'h0);

      // Clean press with ready low.
      a8 = 8'hFD;
      b8 = 8'h07;
      pb = 1'b1;
      wait_pulse(lat);
      check("clean_latency", lat, 7);
      tick();
      check("clean_pulse_one_cycle", {31'h0, pbs8}, 32'h0);
      check("clean_valid", {31'h0, valid8}, 32'h1);
      check("clean_mc", {24'h0, mc8}, 32'hFD);
      check("clean_mr", {24'h0, mr8}, 32'h07);
      check("clean_led_pb", {31'h0, ledpb8}, 32'h1);
      count_pulses(50, cnt, first);
      check("hold_no_repulse", cnt, 0);
      pb = 1'b0;
      count_pulses(20, cnt, first);
      check("release_no_pulse", cnt, 0);
      check("release_led_pb", {31'h0, ledpb8}, 32'h0);
      check("w16_mc", {16'h0, mc16}, 32'h8000);
      check("w16_mr", {16'h0, mr16}, 32'h7FFF);
      check("w16_led", led16, 32'h80007FFF);

      // Handshake: operands held while valid, then drained by one ready cycle.
      a8 = 8'h10;
      repeat (3) tick();
      check("hs_mc_stable", {24'h0, mc8}, 32'hFD);
      check("hs_valid_held", {31'h0, valid8}, 32'h1);
      check("hs_led_live", {16'h0, led8}, 32'h1007);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("hs_valid_drop", {31'h0, valid8}, 32'h0);
      check("hs_mc_after", {24'h0, mc8}, 32'hFD);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("hs_ready_idle_ignored", {31'h0, valid8}, 32'h0);

      // Press table: capture, overrun, simultaneous press and ready.
      for (int i = 0; i < 4; i++) begin
         a8 = tbl[i].a;
         b8 = tbl[i].b;
         pb = 1'b1;
         wait_pulse(lat);
         check($sformatf("tbl%0d_latency", i), lat, 7);
         ready = tbl[i].rdy;
         tick();
         ready = 1'b0;
         check($sformatf("tbl%0d_mc", i), {24'h0, mc8}, {24'h0, tbl[i].mc});
         check($sformatf("tbl%0d_mr", i), {24'h0, mr8}, {24'h0, tbl[i].mr});
         check($sformatf("tbl%0d_valid", i), {31'h0, valid8}, {31'h0, tbl[i].v});
         check($sformatf("tbl%0d_overrun", i), {31'h0, ovr8}, {31'h0, tbl[i].ov});
         pb = 1'b0;
         repeat (20) tick();
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("drain_valid", {31'h0, valid8}, 32'h0);

      // Bouncy press: toggle every 2 cycles, then hold.
      a8  = 8'h01;
      b8  = 8'hFF;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         pb = ((i / 2) % 2) == 0;
         tick();
         if (pbs8) cnt++;
      end
      check("bounce_no_pulse", cnt, 0);
      pb = 1'b1;
      count_pulses(30, cnt, first);
      check("bounce_one_pulse", cnt, 1);
      check("bounce_latency", first, 7);
      count_pulses(50, cnt, first);
      check("bounce_hold_no_repulse", cnt, 0);
      check("bounce_mc", {24'h0, mc8}, 32'h01);
      check("bounce_mr", {24'h0, mr8}, 32'hFF);
      pb = 1'b0;
      repeat (20) tick();

      // Reset in the middle of a debounce aborts it.
      pb = 1'b1;
      repeat (4) tick();
      reset = 1'b1;
      pb    = 1'b0;
      tick();
      reset = 1'b0;
      count_pulses(15, cnt, first);
      check("midrst_no_pulse", cnt, 0);
      check("midrst_valid", {31'h0, valid8}, 32'h0);
      check("midrst_overrun", {31'h0, ovr8}, 32'h0);
      check("midrst_mc", {24'h0, mc8}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
